// File: rtl/stack_machine_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stack_machine_pkg
// Description : Shared opcodes, error codes, FSM state encoding and stack
//               control encoding for the parametrised stack machine.
// Revision    : 1.0 - initial release
// ============================================================================
package stack_machine_pkg;

  // Instruction opcodes (instr[IMM_W+2:IMM_W])
  localparam logic [2:0] OP_PUSH  = 3'b000;
  localparam logic [2:0] OP_ADD   = 3'b001;
  localparam logic [2:0] OP_SUB   = 3'b010;
  localparam logic [2:0] OP_MUL   = 3'b011;
  localparam logic [2:0] OP_DUP   = 3'b100;
  localparam logic [2:0] OP_SWAP  = 3'b101;
  localparam logic [2:0] OP_POP   = 3'b110;
  localparam logic [2:0] OP_UNDEF = 3'b111;

  // err_code values
  localparam logic [2:0] ERR_NONE = 3'b000;
  localparam logic [2:0] ERR_OVF  = 3'b001;
  localparam logic [2:0] ERR_UND  = 3'b010;
  localparam logic [2:0] ERR_UNF  = 3'b100;

  // Controller states
  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_DECODE = 3'd1,
    ST_POP_A  = 3'd2,
    ST_POP_B  = 3'd3,
    ST_WRITE  = 3'd4,
    ST_ERR    = 3'd5,
    ST_DONE   = 3'd6
  } state_t;

  // Stack operation requested for the current cycle
  typedef enum logic [1:0] {
    SC_NOP  = 2'd0,
    SC_PUSH = 2'd1,
    SC_POP  = 2'd2,
    SC_SWAP = 2'd3
  } stack_ctrl_t;

endpackage
`default_nettype wire

// File: rtl/stack_mem_p.sv
`default_nettype none
// ============================================================================
// Module      : stack_mem_p
// Description : Register-array LIFO. Top and next entries are read
//               combinationally; SWAP exchanges them in a single cycle.
//               Operations that would over/underflow are ignored here; the
//               controller is expected to screen them beforehand.
// Revision    : 1.0 - initial release
// ============================================================================
module stack_mem_p
  import stack_machine_pkg::*;
#(
  parameter int DW    = 20,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  stack_ctrl_t                ctrl,
  input  logic [DW-1:0]              w_data,
  output logic [DW-1:0]              r_data,
  output logic [DW-1:0]              r_next,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] r_mem [DEPTH];
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_top_c;
  logic [CW-1:0] w_nxt_c;
  logic [AW-1:0] w_top_idx;
  logic [AW-1:0] w_nxt_idx;
  logic [AW-1:0] w_push_idx;
  logic          w_two;

  assign w_top_c    = r_count - CW'(1);
  assign w_nxt_c    = r_count - CW'(2);
  assign w_top_idx  = w_top_c[AW-1:0];
  assign w_nxt_idx  = w_nxt_c[AW-1:0];
  assign w_push_idx = r_count[AW-1:0];
  assign w_two      = (r_count >= CW'(2));

  assign full   = (r_count == CW'(DEPTH));
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign r_data = empty ? '0 : r_mem[w_top_idx];
  assign r_next = w_two ? r_mem[w_nxt_idx] : '0;

  // Occupancy counter: saturates at 0 and DEPTH so the pointer never wraps
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else begin
      case (ctrl)
        SC_PUSH: if (!full)  r_count <= r_count + CW'(1);
        SC_POP:  if (!empty) r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array: written on push and swap, contents are don't-care above count
  always_ff @(posedge clk) begin
    case (ctrl)
      SC_PUSH: if (!full) r_mem[w_push_idx] <= w_data;
      SC_SWAP: if (w_two) begin
        r_mem[w_top_idx] <= r_next;
        r_mem[w_nxt_idx] <= r_data;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/stack_machine_p.sv
`default_nettype none
// ============================================================================
// Module      : stack_machine_p
// Description : Parametrised stack machine. Reads len from the word at
//               pc=all-ones, then executes len instructions on a DEPTH-deep
//               LIFO. Stack checks happen in DECODE so a failing instruction
//               never touches the stack.
// Config      : SM_SAT_EN - when defined, ADD/SUB/MUL saturate to the signed
//               DW-bit range instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module stack_machine_p
  import stack_machine_pkg::*;
#(
  parameter int DW    = 20,
  parameter int IMM_W = 10,
  parameter int DEPTH = 8,
  parameter int PC_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IMM_W+2:0]  instr,
  output logic [PC_W-1:0]   pc,
  output logic              d_valid,
  output logic [DW-1:0]     out_data,
  output logic [2:0]        err_code,
  output logic              fin
);

  localparam int CW = $clog2(DEPTH+1);
  localparam logic [DW-1:0] c_MAX_DW = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] c_MIN_DW = {1'b1, {(DW-1){1'b0}}};

  state_t          r_state, w_next;
  logic [PC_W-1:0] r_pc, w_pc_next, w_pc_inc;
  logic [PC_W-1:0] r_len, w_len_next, w_len_in;
  logic [2:0]      r_err, w_err_next;
  logic [DW-1:0]   r_a, r_b;

  logic [2:0]      w_op;
  logic [DW-1:0]   w_imm;
  stack_ctrl_t     w_ctrl;
  logic [DW-1:0]   w_wdata, w_top, w_unused_next;
  logic [CW-1:0]   w_count;
  logic            w_full, w_empty, w_lt2, w_end;
  logic            w_dv;
  logic [DW-1:0]   w_out;
  logic [2:0]      w_errc;

  logic signed [2*DW-1:0] w_a_x, w_b_x, w_wide;
  logic [DW-1:0]          w_res;

  assign w_op     = instr[IMM_W+2:IMM_W];
  assign w_imm    = DW'($signed(instr[IMM_W-1:0]));
  assign w_lt2    = (w_count < CW'(2));
  assign w_pc_inc = r_pc + PC_W'(1);

  // Program length comes from the low bits of the word at pc=all-ones
  generate
    if (PC_W <= IMM_W + 3) begin : g_len_trunc
      assign w_len_in = instr[PC_W-1:0];
    end else begin : g_len_ext
      assign w_len_in = {{(PC_W-IMM_W-3){1'b0}}, instr};
    end
  endgenerate

  stack_mem_p #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk    (clk),
    .rst    (rst),
    .ctrl   (w_ctrl),
    .w_data (w_wdata),
    .r_data (w_top),
    .r_next (w_unused_next),
    .count  (w_count),
    .full   (w_full),
    .empty  (w_empty)
  );

  // Full-precision arithmetic on the popped operands (A = old top, B = next)
  always_comb begin
    w_a_x = (2*DW)'($signed(r_a));
    w_b_x = (2*DW)'($signed(r_b));
    case (w_op)
      OP_ADD:  w_wide = w_a_x + w_b_x;
      OP_SUB:  w_wide = w_a_x - w_b_x;
      default: w_wide = w_a_x * w_b_x;
    endcase
    w_res = w_wide[DW-1:0];
`ifdef SM_SAT_EN
    if (w_wide > (2*DW)'($signed(c_MAX_DW)))
      w_res = c_MAX_DW;
    else if (w_wide < (2*DW)'($signed(c_MIN_DW)))
      w_res = c_MIN_DW;
`endif
  end

`ifndef SM_SAT_EN
  logic w_unused_hi;
  assign w_unused_hi = ^{w_wide[2*DW-1:DW], c_MAX_DW, c_MIN_DW};
`endif

  // Controller state and architectural registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_INIT;
      r_pc    <= '1;
      r_len   <= '0;
      r_err   <= ERR_NONE;
      r_a     <= '0;
      r_b     <= '0;
    end else begin
      r_state <= w_next;
      r_pc    <= w_pc_next;
      r_len   <= w_len_next;
      r_err   <= w_err_next;
      if (r_state == ST_POP_A) r_a <= w_top;
      if (r_state == ST_POP_B) r_b <= w_top;
    end
  end

  // Next-state, stack control and output decode
  always_comb begin
    w_next     = r_state;
    w_pc_next  = r_pc;
    w_len_next = r_len;
    w_err_next = r_err;
    w_ctrl     = SC_NOP;
    w_wdata    = '0;
    w_dv       = 1'b0;
    w_out      = '0;
    w_errc     = ERR_NONE;
    w_end      = 1'b0;

    case (r_state)
      ST_INIT: begin
        w_len_next = w_len_in;
        w_pc_next  = '0;
        w_next     = (w_len_in == '0) ? ST_DONE : ST_DECODE;
      end
      ST_DECODE: begin
        case (w_op)
          OP_PUSH: begin
            if (w_full) begin w_err_next = ERR_OVF; w_next = ST_ERR; end
            else        w_next = ST_WRITE;
          end
          OP_DUP: begin
            if (w_empty)     begin w_err_next = ERR_UNF; w_next = ST_ERR; end
            else if (w_full) begin w_err_next = ERR_OVF; w_next = ST_ERR; end
            else             w_next = ST_WRITE;
          end
          OP_SWAP: begin
            if (w_lt2) begin w_err_next = ERR_UNF; w_next = ST_ERR; end
            else       w_next = ST_WRITE;
          end
          OP_POP: begin
            if (w_empty) begin w_err_next = ERR_UNF; w_next = ST_ERR; end
            else         w_next = ST_POP_A;
          end
          OP_ADD, OP_SUB, OP_MUL: begin
            if (w_lt2) begin w_err_next = ERR_UNF; w_next = ST_ERR; end
            else       w_next = ST_POP_A;
          end
          default: begin
            w_err_next = ERR_UND;
            w_next     = ST_ERR;
          end
        endcase
      end
      ST_POP_A: begin
        w_ctrl = SC_POP;
        if (w_op == OP_POP) begin
          w_dv  = 1'b1;
          w_out = w_top;
          w_end = 1'b1;
        end else begin
          w_next = ST_POP_B;
        end
      end
      ST_POP_B: begin
        w_ctrl = SC_POP;
        w_next = ST_WRITE;
      end
      ST_WRITE: begin
        w_end = 1'b1;
        case (w_op)
          OP_PUSH: begin w_ctrl = SC_PUSH; w_wdata = w_imm; end
          OP_DUP:  begin w_ctrl = SC_PUSH; w_wdata = w_top; end
          OP_SWAP: w_ctrl = SC_SWAP;
          OP_ADD, OP_SUB, OP_MUL: begin
            w_ctrl  = SC_PUSH;
            w_wdata = w_res;
            w_dv    = 1'b1;
            w_out   = w_res;
          end
          default: ;
        endcase
      end
      ST_ERR: begin
        w_dv   = 1'b1;
        w_errc = r_err;
        w_end  = 1'b1;
      end
      default: ;
    endcase

    if (w_end) begin
      w_pc_next = w_pc_inc;
      w_next    = (w_pc_inc == r_len) ? ST_DONE : ST_DECODE;
    end
  end

  assign pc       = r_pc;
  assign fin      = (r_pc == r_len);
  assign d_valid  = w_dv & ~rst;
  assign out_data = rst ? '0 : w_out;
  assign err_code = rst ? ERR_NONE : w_errc;

endmodule
`default_nettype wire

// File: tb/tb_stack_machine_p.sv
`default_nettype none
// ============================================================================
// Module      : tb_stack_machine_p
// Description : Self-checking bench for stack_machine_p with a queue-based
//               reference model of the instruction set.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stack_machine_p;
  import stack_machine_pkg::*;

  localparam int DEPTH = 8;
`ifdef SM_SAT_EN
  localparam logic [19:0] MUL2_RES = 20'h7FFFF;
`else
  localparam logic [19:0] MUL2_RES = 20'h00000;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [12:0] instr;
  logic [9:0]  pc;
  logic        d_valid;
  logic [19:0] out_data;
  logic [2:0]  err_code;
  logic        fin;

  stack_machine_p dut (
    .clk(clk), .rst(rst), .instr(instr), .pc(pc), .d_valid(d_valid),
    .out_data(out_data), .err_code(err_code), .fin(fin)
  );

  always #5 clk = ~clk;

  logic [12:0] prog [0:1023];
  int          prog_len = 0;
  assign instr = (pc == 10'h3FF) ? 13'(prog_len) : prog[pc];

  typedef struct { int cyc; logic [19:0] data; logic [2:0] err; } ev_t;
  ev_t exp_q[$];
  ev_t obs_q[$];
  int  exp_fin_cyc, obs_fin_cyc, exp_count, idle_bad;
  int  checks = 0;
  int  errors = 0;

  function automatic logic [12:0] ins(input logic [2:0] op, input logic [9:0] imm);
    return {op, imm};
  endfunction

  function automatic logic [19:0] fit(input longint v);
`ifdef SM_SAT_EN
    if (v > 64'sd524287)  return 20'h7FFFF;
    if (v < -64'sd524288) return 20'h80000;
`endif
    return v[19:0];
  endfunction

  // Reference model: runs the program on a queue, records each strobe and its cycle
  task automatic model_prog();
    logic [19:0] st[$];
    logic [2:0]  op;
    logic [19:0] a, b, se, ev_data;
    logic [2:0]  ev_err;
    longint      la, lb, r;
    int          cyc, lat, n;
    bit          has_ev;
    ev_t         e;
    exp_q.delete();
    cyc = 1;
    for (int i = 0; i < prog_len; i++) begin
      op = prog[i][12:10];
      se = 20'($signed(prog[i][9:0]));
      lat = 2; has_ev = 0; ev_data = '0; ev_err = 3'b000;
      n = st.size();
      case (op)
        3'b000: if (n == DEPTH) begin has_ev = 1; ev_err = 3'b001; end
                else st.push_back(se);
        3'b100: if (n == 0) begin has_ev = 1; ev_err = 3'b100; end
                else if (n == DEPTH) begin has_ev = 1; ev_err = 3'b001; end
                else st.push_back(st[n-1]);
        3'b101: if (n < 2) begin has_ev = 1; ev_err = 3'b100; end
                else begin a = st[n-1]; st[n-1] = st[n-2]; st[n-2] = a; end
        3'b110: if (n == 0) begin has_ev = 1; ev_err = 3'b100; end
                else begin has_ev = 1; ev_data = st.pop_back(); end
        3'b001, 3'b010, 3'b011: begin
          if (n < 2) begin has_ev = 1; ev_err = 3'b100; end
          else begin
            lat = 4;
            a = st.pop_back(); b = st.pop_back();
            la = longint'($signed(a)); lb = longint'($signed(b));
            r = (op == 3'b001) ? la + lb : (op == 3'b010) ? la - lb : la * lb;
            ev_data = fit(r);
            st.push_back(ev_data);
            has_ev = 1;
          end
        end
        default: begin has_ev = 1; ev_err = 3'b010; end
      endcase
      if (has_ev) begin
        e.cyc = cyc + lat - 1; e.data = ev_data; e.err = ev_err;
        exp_q.push_back(e);
      end
      cyc += lat;
    end
    exp_fin_cyc = cyc;
    exp_count   = st.size();
  endtask

  // Reset, then run the DUT until fin or a cycle budget, logging strobes
  task automatic run_prog();
    ev_t e;
    int  cyc;
    obs_q.delete();
    idle_bad = 0;
    obs_fin_cyc = -1;
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    cyc = 0;
    while (cyc <= exp_fin_cyc + 8) begin
      if (d_valid) begin
        e.cyc = cyc; e.data = out_data; e.err = err_code;
        obs_q.push_back(e);
      end else if (out_data !== '0 || err_code !== 3'b000) begin
        idle_bad++;
      end
      if (fin) begin obs_fin_cyc = cyc; break; end
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic load_directed(input int k);
    for (int i = 0; i < 1024; i++) prog[i] = '0;
    case (k)
      0: begin prog_len = 3; prog[0] = ins(3'b000, 10'd5); prog[1] = ins(3'b000, 10'h3FD);
               prog[2] = ins(3'b001, 10'd0); end
      1: begin prog_len = 3; prog[0] = ins(3'b000, 10'd4); prog[1] = ins(3'b000, 10'd10);
               prog[2] = ins(3'b010, 10'd0); end
      2: begin prog_len = 4; prog[0] = ins(3'b000, 10'd4); prog[1] = ins(3'b000, 10'd10);
               prog[2] = ins(3'b101, 10'd0); prog[3] = ins(3'b010, 10'd0); end
      3: begin prog_len = 5; prog[0] = ins(3'b000, 10'h200); prog[1] = ins(3'b100, 10'd0);
               prog[2] = ins(3'b011, 10'd0); prog[3] = ins(3'b100, 10'd0);
               prog[4] = ins(3'b011, 10'd0); end
      4: begin prog_len = 9;
               for (int i = 0; i < 9; i++) prog[i] = ins(3'b000, 10'(i + 1)); end
      default: begin prog_len = 4; prog[0] = ins(3'b000, 10'd7); prog[1] = ins(3'b001, 10'd0);
               prog[2] = ins(3'b110, 10'd0); prog[3] = ins(3'b111, 10'd0); end
    endcase
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (pc !== 10'h3FF) begin errors++; $display("FAIL reset_pc got %h want 3ff", pc); end
    checks++; if (dut.r_state !== ST_INIT) begin errors++; $display("FAIL reset_state got %0d want %0d", dut.r_state, ST_INIT); end
    checks++; if (dut.u_stack.r_count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", dut.u_stack.r_count); end
    checks++; if ({d_valid, out_data, err_code, fin} !== 25'd0)
      begin errors++; $display("FAIL reset_outputs got dv=%b data=%h err=%b fin=%b want all 0", d_valid, out_data, err_code, fin); end
  endtask

  task automatic test_directed();
    logic [19:0] wfd [6] = '{20'h00002, 20'h00006, 20'hFFFFA, 20'h40000, 20'h0, 20'h0};
    logic [2:0]  wfe [6] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b001, 3'b100};
    logic [19:0] wld [6] = '{20'h00002, 20'h00006, 20'hFFFFA, MUL2_RES, 20'h0, 20'h0};
    logic [2:0]  wle [6] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b001, 3'b010};
    int          wcnt [6] = '{1, 1, 1, 1, 8, 0};
    int          nq;
    for (int k = 0; k < 6; k++) begin
      load_directed(k);
      model_prog();
      run_prog();
      nq = obs_q.size();
      checks++; if (nq == 0) begin errors++; $display("FAIL dir%0d_no_strobe got 0 strobes", k); end
      else begin
        checks++; if (obs_q[0].data !== wfd[k] || obs_q[0].err !== wfe[k]) begin errors++;
          $display("FAIL dir%0d_first got %h/%b want %h/%b", k, obs_q[0].data, obs_q[0].err, wfd[k], wfe[k]); end
        checks++; if (obs_q[nq-1].data !== wld[k] || obs_q[nq-1].err !== wle[k]) begin errors++;
          $display("FAIL dir%0d_last got %h/%b want %h/%b", k, obs_q[nq-1].data, obs_q[nq-1].err, wld[k], wle[k]); end
      end
      checks++; if (dut.u_stack.r_count !== 4'(wcnt[k])) begin errors++;
        $display("FAIL dir%0d_count got %0d want %0d", k, dut.u_stack.r_count, wcnt[k]); end
      checks++; if (nq != exp_q.size()) begin errors++;
        $display("FAIL dir%0d_nstrobe got %0d want %0d", k, nq, exp_q.size()); end
      for (int j = 0; j < nq && j < exp_q.size(); j++) begin
        checks++; if (obs_q[j].cyc != exp_q[j].cyc || obs_q[j].data !== exp_q[j].data || obs_q[j].err !== exp_q[j].err) begin
          errors++; $display("FAIL dir%0d_ev%0d got c%0d %h/%b want c%0d %h/%b", k, j,
            obs_q[j].cyc, obs_q[j].data, obs_q[j].err, exp_q[j].cyc, exp_q[j].data, exp_q[j].err); end
      end
      checks++; if (obs_fin_cyc != exp_fin_cyc || pc !== 10'(prog_len)) begin errors++;
        $display("FAIL dir%0d_fin got cyc %0d pc %0d want cyc %0d pc %0d", k, obs_fin_cyc, pc, exp_fin_cyc, prog_len); end
      checks++; if (idle_bad != 0) begin errors++; $display("FAIL dir%0d_idle got %0d nonzero idle cycles want 0", k, idle_bad); end
    end
  endtask

  task automatic test_random();
    int r;
    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < 1024; i++) prog[i] = '0;
      prog_len = $urandom_range(1, 30);
      for (int i = 0; i < prog_len; i++) begin
        r = $urandom_range(0, 10);
        prog[i] = ins((r < 4) ? 3'b000 : 3'(r - 3), 10'($urandom));
      end
      model_prog();
      run_prog();
      checks++; if (obs_q.size() != exp_q.size()) begin errors++;
        $display("FAIL rnd%0d_nstrobe got %0d want %0d", t, obs_q.size(), exp_q.size()); end
      for (int j = 0; j < obs_q.size() && j < exp_q.size(); j++) begin
        checks++; if (obs_q[j].cyc != exp_q[j].cyc || obs_q[j].data !== exp_q[j].data || obs_q[j].err !== exp_q[j].err) begin
          errors++; $display("FAIL rnd%0d_ev%0d got c%0d %h/%b want c%0d %h/%b", t, j,
            obs_q[j].cyc, obs_q[j].data, obs_q[j].err, exp_q[j].cyc, exp_q[j].data, exp_q[j].err); end
      end
      checks++; if (obs_fin_cyc != exp_fin_cyc || dut.u_stack.r_count !== 4'(exp_count)) begin errors++;
        $display("FAIL rnd%0d_end got cyc %0d cnt %0d want cyc %0d cnt %0d", t, obs_fin_cyc,
          dut.u_stack.r_count, exp_fin_cyc, exp_count); end
      checks++; if (idle_bad != 0) begin errors++; $display("FAIL rnd%0d_idle got %0d want 0", t, idle_bad); end
    end
  endtask

  task automatic test_reset_midway();
    load_directed(1);
    model_prog();
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    repeat (7) begin @(posedge clk); #1; end
    checks++; if (dut.r_state !== ST_POP_B) begin errors++;
      $display("FAIL mid_state got %0d want %0d", dut.r_state, ST_POP_B); end
    rst = 1'b1;
    #1;
    checks++; if (d_valid !== 1'b0 || out_data !== '0) begin errors++;
      $display("FAIL mid_rst_out got dv=%b data=%h want 0", d_valid, out_data); end
    @(posedge clk); #1;
    checks++; if (pc !== 10'h3FF || dut.r_state !== ST_INIT || dut.u_stack.r_count !== 4'd0 || d_valid !== 1'b0) begin
      errors++; $display("FAIL mid_after got pc=%h st=%0d cnt=%0d dv=%b want 3ff/%0d/0/0",
        pc, dut.r_state, dut.u_stack.r_count, d_valid, ST_INIT); end
    run_prog();
    checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL mid_rerun_n got %0d want 1", obs_q.size()); end
    else begin
      checks++; if (obs_q[0].data !== 20'h00006 || obs_q[0].cyc != exp_q[0].cyc) begin errors++;
        $display("FAIL mid_rerun got %h at %0d want 00006 at %0d", obs_q[0].data, obs_q[0].cyc, exp_q[0].cyc); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) prog[i] = '0;
    test_reset();
    test_directed();
    test_random();
    test_reset_midway();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
